// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider (one quotient bit per clock) with signed mode and ALU status flags
module seq_divider #(
  parameter int N = 32,
  localparam int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dz_flag,
  output logic         of_flag,
  output logic         zr_flag,
  output logic         neg_flag
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [N-1:0] r_rem, r_dq, r_dvs, r_dvd_orig;
  logic r_neg_q, r_neg_r, r_dz, r_of;
  logic w_dvd_neg, w_dvs_neg, w_last, w_no_borrow;
  logic [N-1:0] w_rem_lo, w_rem_next, w_q_next, w_q_fin, w_r_fin;
  logic [N:0] w_trial;
  assign w_dvd_neg = signed_op & dividend[N-1];
  assign w_dvs_neg = signed_op & divisor[N-1];
  assign w_last = (r_cnt == CW'(N - 1));
  // The bit shifted out of the remainder acts as the (N+1)-th minuend bit,
  // so an N-bit subtraction plus that bit decides the quotient bit.
  assign w_rem_lo = {r_rem[N-2:0], r_dq[N-1]};
  assign w_trial = {1'b0, w_rem_lo} - {1'b0, r_dvs};
  assign w_no_borrow = r_rem[N-1] | ~w_trial[N];
  assign w_rem_next = w_no_borrow ? w_trial[N-1:0] : w_rem_lo;
  assign w_q_next = {r_dq[N-2:0], w_no_borrow};
  assign w_q_fin = r_dz ? '1 : (r_neg_q ? -w_q_next : w_q_next);
  assign w_r_fin = r_dz ? r_dvd_orig : (r_neg_r ? -w_rem_next : w_rem_next);

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  // next-state and handshake outputs
  always_comb begin
    w_next = r_state;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_IDLE: w_next = start ? S_CALC : S_IDLE;
      S_CALC: begin
        busy = 1'b1;
        w_next = w_last ? S_DONE : S_CALC;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // operand capture on accepted start, then one shift/subtract step per CALC cycle;
  // a zero divisor preloads the counter so a single pass reaches DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_dq <= '0;
      r_dvs <= '0;
      r_dvd_orig <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz <= 1'b0;
      r_of <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_cnt <= (divisor == '0) ? CW'(N - 1) : '0;
      r_rem <= '0;
      r_dq <= w_dvd_neg ? -dividend : dividend;
      r_dvs <= w_dvs_neg ? -divisor : divisor;
      r_dvd_orig <= dividend;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
      r_dz <= (divisor == '0);
      r_of <= signed_op & (dividend == {1'b1, {(N-1){1'b0}}}) & (&divisor);
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_rem_next;
      r_dq <= w_q_next;
    end

  // sign-corrected results and flags, registered on the final iteration and held until the next one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      quotient <= '0;
      remainder <= '0;
      dz_flag <= 1'b0;
      of_flag <= 1'b0;
      zr_flag <= 1'b0;
      neg_flag <= 1'b0;
    end else if (r_state == S_CALC && w_last) begin
      quotient <= w_q_fin;
      remainder <= w_r_fin;
      dz_flag <= r_dz;
      of_flag <= r_of;
      zr_flag <= (w_q_fin == '0);
      neg_flag <= w_q_fin[N-1];
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider (N=32 and N=8) against an arithmetic model
module tb_seq_divider;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic s_start, s_sop;
  logic [31:0] s_a, s_b, q32, r32;
  logic b32, d32, dz32, of32, zr32, ng32;
  logic e_start, e_sop;
  logic [7:0] e_a, e_b, q8, r8;
  logic b8, d8, dz8, of8, zr8, ng8;
  int checks = 0;
  int errors = 0;

  seq_divider #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .signed_op(s_sop), .dividend(s_a), .divisor(s_b),
    .busy(b32), .done(d32), .quotient(q32), .remainder(r32),
    .dz_flag(dz32), .of_flag(of32), .zr_flag(zr32), .neg_flag(ng32));

  seq_divider #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(e_start), .signed_op(e_sop), .dividend(e_a), .divisor(e_b),
    .busy(b8), .done(d8), .quotient(q8), .remainder(r8),
    .dz_flag(dz8), .of_flag(of8), .zr_flag(zr8), .neg_flag(ng8));

  // reference: integer division truncating toward zero on w-bit values; flags {dz,of,zr,neg}
  function automatic void model(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic [3:0] fl);
    longint m, sa, sb;
    m = (longint'(1) << w) - 1;
    if (b == 0) begin
      q = 32'(m);
      r = a;
      fl = 4'b1001;
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[w-1]) sa -= (longint'(1) << w);
      if (s && b[w-1]) sb -= (longint'(1) << w);
      q = 32'((sa / sb) & m);
      r = 32'((sa % sb) & m);
      fl = {1'b0, s && b == 32'(m) && a == 32'(longint'(1) << (w - 1)), q == 0, q[w-1]};
    end
  endfunction

  task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic [3:0] fl,
                       output int lat, output int bcnt);
    @(negedge clk);
    s_start = 1'b1; s_sop = s; s_a = a; s_b = b;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    lat = 0; bcnt = 0;
    while (!d32 && lat < 100) begin
      bcnt += int'(b32);
      @(posedge clk); lat++; @(negedge clk);
    end
    bcnt += int'(b32);
    q = q32; r = r32; fl = {dz32, of32, zr32, ng32};
  endtask

  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] q, output logic [7:0] r, output logic [3:0] fl, output int lat);
    @(negedge clk);
    e_start = 1'b1; e_sop = s; e_a = a; e_b = b;
    @(posedge clk);
    @(negedge clk);
    e_start = 1'b0;
    lat = 0;
    while (!d8 && lat < 30) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    q = q8; r = r8; fl = {dz8, of8, zr8, ng8};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({b32, d32, q32, r32, dz32, of32, zr32, ng32} !== 70'd0) begin
      errors++; $display("FAIL reset32: got %h required 0", {b32, d32, q32, r32, dz32, of32, zr32, ng32});
    end
    checks++;
    if ({b8, d8, q8, r8, dz8, of8, zr8, ng8} !== 22'd0) begin
      errors++; $display("FAIL reset8: got %h required 0", {b8, d8, q8, r8, dz8, of8, zr8, ng8});
    end
    rst_n = 1'b1;
  endtask

  typedef struct { logic s; logic [31:0] a; logic [31:0] b; } op_t;

  task automatic test_directed;
    op_t ops[6] = '{'{1'b0, 32'd100, 32'd7}, '{1'b1, 32'hFFFF_FFF9, 32'd2}, '{1'b1, 32'd7, 32'hFFFF_FFFE},
                    '{1'b0, 32'h1234, 32'd0}, '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF},
                    '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF}};
    logic [31:0] q, r, eq, er;
    logic [3:0] fl, ef;
    int lat, bc, el;
    foreach (ops[i]) begin
      run32(ops[i].s, ops[i].a, ops[i].b, q, r, fl, lat, bc);
      model(32, ops[i].s, ops[i].a, ops[i].b, eq, er, ef);
      el = (ops[i].b == 0) ? 1 : 32;
      checks++;
      if (q !== eq) begin errors++; $display("FAIL dir%0d quotient: got %h required %h", i, q, eq); end
      checks++;
      if (r !== er) begin errors++; $display("FAIL dir%0d remainder: got %h required %h", i, r, er); end
      checks++;
      if (fl !== ef) begin errors++; $display("FAIL dir%0d flags: got %b required %b", i, fl, ef); end
      checks++;
      if (lat != el) begin errors++; $display("FAIL dir%0d latency: got %0d required %0d", i, lat, el); end
      checks++;
      if (bc != el + 1) begin errors++; $display("FAIL dir%0d busy_cycles: got %0d required %0d", i, bc, el + 1); end
      repeat (3) @(negedge clk);
      checks++;
      if ({q32, r32, dz32, of32, zr32, ng32} !== {eq, er, ef}) begin
        errors++; $display("FAIL dir%0d hold: got %h/%h required %h/%h", i, q32, r32, eq, er);
      end
    end
  endtask

  task automatic test_random32;
    logic [31:0] a, b, q, r, eq, er;
    logic [3:0] fl, ef;
    logic s;
    int lat, bc;
    for (int k = 0; k < 150; k++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (k % 9 == 0) b = 32'($urandom_range(0, 3));
      if (k % 13 == 0) b = 32'hFFFF_FFFF;
      run32(s, a, b, q, r, fl, lat, bc);
      model(32, s, a, b, eq, er, ef);
      checks++;
      if ({q, r, fl} !== {eq, er, ef}) begin
        errors++; $display("FAIL rand32 s=%0d %h/%h: got q=%h r=%h f=%b required q=%h r=%h f=%b", s, a, b, q, r, fl, eq, er, ef);
      end
      checks++;
      if (lat != ((b == 0) ? 1 : 32)) begin errors++; $display("FAIL rand32 latency: got %0d for divisor %h", lat, b); end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    s_start = 1'b1; s_sop = 1'b0; s_a = 32'd100; s_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    lat = 0;
    while (!d32 && lat < 100) begin
      s_start = (lat == 10);
      if (lat == 10) begin s_a = 32'd999; s_b = 32'd5; end
      @(posedge clk); lat++; @(negedge clk);
    end
    s_start = 1'b0;
    checks++;
    if ({q32, r32} !== {32'd14, 32'd2}) begin errors++; $display("FAIL ignore_start result: got %0d/%0d required 14/2", q32, r32); end
    checks++;
    if (lat != 32) begin errors++; $display("FAIL ignore_start latency: got %0d required 32", lat); end
    @(negedge clk);
    checks++;
    if (b32 !== 1'b0) begin errors++; $display("FAIL ignore_start queued: busy %b required 0", b32); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] q, r;
    logic [3:0] fl;
    int lat, bc, seen;
    @(negedge clk);
    s_start = 1'b1; s_sop = 1'b0; s_a = 32'hFFFF; s_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b32, d32, q32, r32, dz32, of32, zr32, ng32} !== 70'd0) begin
      errors++; $display("FAIL midop_reset outputs: got %h required 0", {b32, d32, q32, r32, dz32, of32, zr32, ng32});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); seen += int'(d32); end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midop_reset done_pulses: got %0d required 0", seen); end
    run32(1'b0, 32'd9, 32'd3, q, r, fl, lat, bc);
    checks++;
    if ({q, r} !== {32'd3, 32'd0}) begin errors++; $display("FAIL after_reset 9/3: got %0d/%0d required 3/0", q, r); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    s_start = 1'b1; s_sop = 1'b0; s_a = 32'd100; s_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    lat = 0;
    while (!d32 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    s_start = 1'b1; s_a = 32'd20; s_b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (b32 !== 1'b0) begin errors++; $display("FAIL b2b start_during_done: busy %b required 0", b32); end
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    checks++;
    if (b32 !== 1'b1) begin errors++; $display("FAIL b2b accept_next_idle: busy %b required 1", b32); end
    lat = 0;
    while (!d32 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    checks++;
    if ({q32, r32, lat} !== {32'd5, 32'd0, 32'd32}) begin
      errors++; $display("FAIL b2b result: got %0d/%0d lat %0d required 5/0 lat 32", q32, r32, lat);
    end
  endtask

  task automatic test_n8;
    logic [7:0] corner[8] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    logic [7:0] a, b, q, r;
    logic [31:0] eq, er;
    logic [3:0] fl, ef;
    logic s;
    int lat;
    for (int k = 0; k < 728; k++) begin
      if (k < 128) begin
        s = 1'(k >> 6); a = corner[(k >> 3) & 7]; b = corner[k & 7];
      end else begin
        s = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
        if (k % 11 == 0) b = 8'h00;
      end
      run8(s, a, b, q, r, fl, lat);
      model(8, s, {24'd0, a}, {24'd0, b}, eq, er, ef);
      checks++;
      if ({q, r, fl} !== {eq[7:0], er[7:0], ef}) begin
        errors++; $display("FAIL n8 s=%0d %h/%h: got q=%h r=%h f=%b required q=%h r=%h f=%b", s, a, b, q, r, fl, eq[7:0], er[7:0], ef);
      end
      checks++;
      if (lat != ((b == 0) ? 1 : 8)) begin errors++; $display("FAIL n8 latency: got %0d for divisor %h", lat, b); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_start = 1'b0; s_sop = 1'b0; s_a = '0; s_b = '0;
    e_start = 1'b0; e_sop = 1'b0; e_a = '0; e_b = '0;
    test_reset;
    test_directed;
    test_random32;
    test_ignore_start;
    test_reset_midop;
    test_back_to_back;
    test_n8;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
